// File: rtl/search_rr.sv
// rtl/search_rr.sv - round-robin capture of one completed search result per handshake
//
// Scans NCH result channels. In SCAN, when release_search is high and any done
// bit is set, it captures the first set channel at or after the rotating pointer.
// The captured address/pixel is held with found=1 until out_ready accepts it.
//
// Parameters:
//   NCH  number of result channels (2..16, any value in range)
//   AW   per-channel address width
//   DW   per-channel pixel width
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   cataddresses   channel i address at [i*AW +: AW]
//   catpixels      channel i pixel at [i*DW +: DW]
//   done           bit i set: channel i holds a result
//   release_search enables new captures
//   out_ready      consumer accepts the held result
//   sel_address    captured address
//   sel_data       captured pixel
//   found          sel_address/sel_data valid
//   mask           one-cycle one-hot pulse naming the channel just captured
//   grant_count    saturating count of delivered results
// Configuration macro:
//   SEARCH_RR_STATS_EN  when defined, grant_count counts deliveries;
//                       otherwise it is tied to zero with no counter flops.

module search_rr #(
    parameter int NCH = 4,
    parameter int AW  = 32,
    parameter int DW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*AW-1:0]  cataddresses,
    input  logic [NCH*DW-1:0]  catpixels,
    input  logic [NCH-1:0]     done,
    input  logic               release_search,
    input  logic               out_ready,
    output logic [AW-1:0]      sel_address,
    output logic [DW-1:0]      sel_data,
    output logic               found,
    output logic [NCH-1:0]     mask,
    output logic [15:0]        grant_count
);

    localparam logic [0:0] ST_SCAN = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int         PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW:0] NCH_W = (PW+1)'(NCH);

    logic [0:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   sel_address_q, sel_address_d;
    logic [DW-1:0]   sel_data_q, sel_data_d;
    logic            found_q, found_d;
    logic [NCH-1:0]  mask_q, mask_d;

    // Winner search: rotate done so that the pointer channel sits at bit 0,
    // take the lowest set bit, then map the offset back to a channel index.
    logic [2*NCH-1:0] done_dbl;
    logic [NCH-1:0]   done_rot;
    logic             rot_hit;
    logic [PW-1:0]    rot_off;
    logic [PW:0]      win_sum;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    ptr_after_win;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_data;
    logic [NCH-1:0]   win_mask;

    assign done_dbl = {done, done};
    assign done_rot = NCH'(done_dbl >> ptr_q);

    always_comb begin
        rot_hit = 1'b0;
        rot_off = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!rot_hit && done_rot[j]) begin
                rot_hit = 1'b1;
                rot_off = PW'(j);
            end
        end
    end

    always_comb begin
        win_sum = {1'b0, ptr_q} + {1'b0, rot_off};
        // Modulo NCH by a single conditional subtract; works for non-power-of-two NCH.
        if (win_sum >= NCH_W) begin
            win_idx = PW'(win_sum - NCH_W);
        end else begin
            win_idx = win_sum[PW-1:0];
        end
        if (win_idx == PW'(NCH - 1)) begin
            ptr_after_win = '0;
        end else begin
            ptr_after_win = win_idx + 1'b1;
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_idx == PW'(i)) begin
                win_addr    = cataddresses[i*AW +: AW];
                win_data    = catpixels[i*DW +: DW];
                win_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_address_d = sel_address_q;
        sel_data_d    = sel_data_q;
        found_d       = found_q;
        mask_d        = '0;
        case (state_q)
            ST_SCAN: begin
                found_d = 1'b0;
                if (release_search && rot_hit) begin
                    sel_address_d = win_addr;
                    sel_data_d    = win_data;
                    found_d       = 1'b1;
                    mask_d        = win_mask;
                    ptr_d         = ptr_after_win;
                    state_d       = ST_HOLD;
                end
            end
            default: begin
                // Held result is released only by out_ready; release_search and
                // done have no effect here.
                if (out_ready) begin
                    found_d = 1'b0;
                    state_d = ST_SCAN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SCAN;
            ptr_q         <= '0;
            sel_address_q <= '0;
            sel_data_q    <= '0;
            found_q       <= 1'b0;
            mask_q        <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            sel_address_q <= sel_address_d;
            sel_data_q    <= sel_data_d;
            found_q       <= found_d;
            mask_q        <= mask_d;
        end
    end

    assign sel_address = sel_address_q;
    assign sel_data    = sel_data_q;
    assign found       = found_q;
    assign mask        = mask_q;

`ifdef SEARCH_RR_STATS_EN
    logic [15:0] grant_count_q, grant_count_d;

    always_comb begin
        grant_count_d = grant_count_q;
        if (found_q && out_ready && (grant_count_q != 16'hFFFF)) begin
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count_q <= 16'h0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`else
    assign grant_count = 16'h0;
`endif

endmodule

// File: tb/tb_search_rr.sv
// tb/tb_search_rr.sv - scoreboard bench for search_rr (NCH=4 and NCH=3 instances)

module tb_search_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: NCH=4
    logic [4*32-1:0] addr_a;
    logic [4*8-1:0]  pix_a;
    logic [3:0]      done_a = '0;
    logic            rel_a = 1'b0;
    logic            rdy_a = 1'b0;
    logic [31:0]     sel_address_a;
    logic [7:0]      sel_data_a;
    logic            found_a;
    logic [3:0]      mask_a;
    logic [15:0]     grant_a;

    // Instance B: NCH=3
    logic [3*32-1:0] addr_b;
    logic [3*8-1:0]  pix_b;
    logic [2:0]      done_b = '0;
    logic            rel_b = 1'b0;
    logic            rdy_b = 1'b0;
    logic [31:0]     sel_address_b;
    logic [7:0]      sel_data_b;
    logic            found_b;
    logic [2:0]      mask_b;
    logic [15:0]     grant_b;

    search_rr #(.NCH(4), .AW(32), .DW(8)) dut_a (
        .clk(clk), .rst(rst), .cataddresses(addr_a), .catpixels(pix_a),
        .done(done_a), .release_search(rel_a), .out_ready(rdy_a),
        .sel_address(sel_address_a), .sel_data(sel_data_a), .found(found_a),
        .mask(mask_a), .grant_count(grant_a)
    );

    search_rr #(.NCH(3), .AW(32), .DW(8)) dut_b (
        .clk(clk), .rst(rst), .cataddresses(addr_b), .catpixels(pix_b),
        .done(done_b), .release_search(rel_b), .out_ready(rdy_b),
        .sel_address(sel_address_b), .sel_data(sel_data_b), .found(found_b),
        .mask(mask_b), .grant_count(grant_b)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int exp_grant_a = 0;

    function automatic logic [31:0] a_addr(int ch);
        return 32'hA000_0000 + 32'h111 * ch;
    endfunction
    function automatic logic [7:0] a_pix(int ch);
        return 8'h30 + 8'h11 * ch[7:0];
    endfunction
    function automatic logic [31:0] b_addr(int ch);
        return 32'hB000_0B00 + 32'h22 * ch;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant_a(input string name);
`ifdef SEARCH_RR_STATS_EN
        chk(name, grant_a, exp_grant_a);
`else
        chk(name, grant_a, 0);
`endif
    endtask

    // Monitor: every mask pulse on instance A must match the next expected capture.
    always @(posedge clk) begin
        #2;
        if (mask_a !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_capture mask=%0h expected=none", mask_a);
            end else begin
                int ch;
                ch = exp_q.pop_front();
                chk("sb_mask", mask_a, 64'(4'b0001 << ch));
                chk("sb_addr", sel_address_a, a_addr(ch));
                chk("sb_data", sel_data_a, a_pix(ch));
                chk("sb_found", found_a, 1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr_a[i*32 +: 32] = a_addr(i);
            pix_a[i*8 +: 8]    = a_pix(i);
        end
        for (int i = 0; i < 3; i++) begin
            addr_b[i*32 +: 32] = b_addr(i);
            pix_b[i*8 +: 8]    = 8'hC0 + 8'(i);
        end

        // Reset state
        tick();
        chk("rst_found", found_a, 0);
        chk("rst_mask", mask_a, 0);
        chk("rst_addr", sel_address_a, 0);
        chk("rst_data", sel_data_a, 0);
        chk("rst_grant", grant_a, 0);
        rst = 1'b0;
        tick();

        // Scenario 1: basic capture of channel 3
        rel_a = 1'b1;
        done_a = 4'b1000;
        exp_q.push_back(3);
        tick();
        chk("s1_found", found_a, 1);
        rdy_a = 1'b1;
        done_a = 4'b0000;
        tick();
        exp_grant_a++;
        chk("s1_release", found_a, 0);
        chk("s1_mask_one_cycle", mask_a, 0);
        chk_grant_a("s1_grant");

        // Scenario 2: fairness 0,1,2,3,0 (ptr back at 0 after channel 3)
        done_a = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("s2_found_toggle", found_a, (k % 2 == 0) ? 1 : 0);
        end
        exp_grant_a += 5;
        chk_grant_a("s2_grant");

        // Scenario 3: pause, then capture channel 2
        rdy_a = 1'b0;
        rel_a = 1'b0;
        done_a = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("s3_pause_found", found_a, 0);
            chk("s3_pause_mask", mask_a, 0);
        end
        rel_a = 1'b1;
        exp_q.push_back(2);
        tick();
        chk("s3_capture", found_a, 1);

        // Scenario 4: backpressure with changing done
        for (int k = 0; k < 5; k++) begin
            done_a = 4'(4'b1111 >> k) ^ 4'(k);
            rel_a = (k != 2);
            tick();
            chk("s4_found", found_a, 1);
            chk("s4_mask", mask_a, 0);
            chk("s4_addr", sel_address_a, a_addr(2));
            chk("s4_data", sel_data_a, a_pix(2));
        end
        rel_a = 1'b0;
        done_a = 4'b0000;
        rdy_a = 1'b1;
        tick();
        exp_grant_a++;
        chk("s4_release", found_a, 0);
        chk("s4_no_capture", mask_a, 0);
        chk_grant_a("s4_grant");

        // Scenario 5: ptr=3 wraps to channel 0, then async reset during HOLD
        rdy_a = 1'b0;
        rel_a = 1'b1;
        done_a = 4'b0001;
        exp_q.push_back(0);
        tick();
        chk("s5_capture", found_a, 1);
        #2;
        rst = 1'b1;
        #1;
        exp_grant_a = 0;
        chk("s5_rst_found", found_a, 0);
        chk("s5_rst_mask", mask_a, 0);
        chk("s5_rst_addr", sel_address_a, 0);
        chk("s5_rst_data", sel_data_a, 0);
        chk("s5_rst_grant", grant_a, 0);
        tick();
        chk("s5_rst_hold", found_a, 0);
        rst = 1'b0;
        chk("s5_after_rst", found_a, 0);
        exp_q.push_back(0);
        tick();
        chk("s5_recapture", found_a, 1);
        chk_grant_a("s5_grant_zero");
        rdy_a = 1'b1;
        done_a = 4'b0000;
        tick();
        exp_grant_a++;
        chk_grant_a("s5_grant_one");
        chk("sb_drained", exp_q.size(), 0);

        // Scenario 6: NCH=3 wrap
        rel_b = 1'b1;
        done_b = 3'b010;
        tick();
        chk("s6_cap1_mask", mask_b, 3'b010);
        rdy_b = 1'b1;
        done_b = 3'b000;
        tick();
        chk("s6_rel1", found_b, 0);
        rdy_b = 1'b0;
        done_b = 3'b001;
        tick();
        chk("s6_wrap_mask", mask_b, 3'b001);
        chk("s6_wrap_addr", sel_address_b, b_addr(0));
        chk("s6_wrap_data", sel_data_b, 8'hC0);
        rdy_b = 1'b1;
        done_b = 3'b000;
        tick();
        rdy_b = 1'b0;
        done_b = 3'b011;
        tick();
        chk("s6_ptr1_mask", mask_b, 3'b010);
`ifdef SEARCH_RR_STATS_EN
        chk("s6_grant", grant_b, 2);
`else
        chk("s6_grant", grant_b, 0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
